// File: rtl/ring_router_mc.sv
// rtl/ring_router_mc.sv - ring router: slide unit to/from neighbours with LOCAL, BYPASS and FORK modes
module ring_router_mc_fifo #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic                           push_i,
    input  logic [DataWidth-1:0]           data_i,
    input  logic                           pop_i,
    output logic [DataWidth-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 push, pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign push    = push_i && (cnt_q != CntWidth'(Depth));
    assign pop     = pop_i && (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + CntWidth'(1);
            else if (pop && !push) cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module ring_router_mc #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 conf_valid_i,
    output logic                 conf_ready_o,
    input  logic                 conf_dir_i,
    input  logic [1:0]           conf_mode_i,
    input  logic [LenWidth-1:0]  conf_len_i,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] sldu_i,
    input  logic                 sldu_valid_i,
    output logic                 sldu_ready_o,
    output logic [DataWidth-1:0] sldu_o,
    output logic                 sldu_valid_o,
    input  logic                 sldu_ready_i,
    input  logic [DataWidth-1:0] ring_left_i,
    input  logic                 ring_left_valid_i,
    output logic                 ring_left_ready_o,
    input  logic [DataWidth-1:0] ring_right_i,
    input  logic                 ring_right_valid_i,
    output logic                 ring_right_ready_o,
    output logic [DataWidth-1:0] ring_left_o,
    output logic                 ring_left_valid_o,
    input  logic                 ring_left_ready_i,
    output logic [DataWidth-1:0] ring_right_o,
    output logic                 ring_right_valid_o,
    input  logic                 ring_right_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;
    localparam logic [1:0]  ModeLocal = 2'd0;
    localparam logic [1:0]  ModeFork  = 2'd2;
    localparam int unsigned CntWidth  = $clog2(FifoDepth + 1);

    state_e               state_q, state_d;
    logic                 dir_q;
    logic [1:0]           mode_q;
    logic [LenWidth-1:0]  len_q, tx_cnt_q, rx_cnt_q;

    logic [DataWidth-1:0] in_l_data, in_r_data, out_l_data, out_r_data, up_data, dn_data;
    logic [CntWidth-1:0]  in_l_cnt, in_r_cnt, out_l_cnt, out_r_cnt, up_cnt;
    logic                 in_l_full, in_r_full, out_l_full, out_r_full;
    logic                 in_l_empty, in_r_empty, out_l_empty, out_r_empty;
    logic                 in_l_push, in_r_push, out_l_push, out_r_push;
    logic                 in_l_pop, in_r_pop, out_l_pop, out_r_pop;
    logic                 up_empty, dn_full, dn_empty, up_pop, dn_push;
    logic                 active, running, tx_open, rx_open, up_budget;
    logic                 tx_inc, rx_inc, cnt_done, cfg_load;

    assign in_l_full   = (in_l_cnt == CntWidth'(FifoDepth));
    assign in_r_full   = (in_r_cnt == CntWidth'(FifoDepth));
    assign out_l_full  = (out_l_cnt == CntWidth'(FifoDepth));
    assign out_r_full  = (out_r_cnt == CntWidth'(FifoDepth));
    assign in_l_empty  = (in_l_cnt == '0);
    assign in_r_empty  = (in_r_cnt == '0);
    assign out_l_empty = (out_l_cnt == '0);
    assign out_r_empty = (out_r_cnt == '0);

    always_comb begin
        up_data   = dir_q ? in_l_data  : in_r_data;
        up_cnt    = dir_q ? in_l_cnt   : in_r_cnt;
        up_empty  = dir_q ? in_l_empty : in_r_empty;
        dn_full   = dir_q ? out_r_full  : out_l_full;
        dn_empty  = dir_q ? out_r_empty : out_l_empty;
        active    = (state_q == StActive) && !flush_i;
        running   = (state_q != StIdle) && !flush_i;
        tx_open   = tx_cnt_q < len_q;
        rx_open   = rx_cnt_q < len_q;
        // Stop accepting ring beats once buffered plus delivered beats cover len.
        up_budget = ({1'b0, rx_cnt_q} + (LenWidth+1)'(up_cnt)) < {1'b0, len_q};

        sldu_ready_o = 1'b0;
        sldu_valid_o = 1'b0;
        up_pop       = 1'b0;
        dn_push      = 1'b0;
        dn_data      = up_data;
        tx_inc       = 1'b0;
        rx_inc       = 1'b0;
        case (mode_q)
            ModeLocal: begin
                sldu_ready_o = active && !dn_full && tx_open;
                dn_push      = sldu_valid_i && sldu_ready_o;
                dn_data      = sldu_i;
                tx_inc       = dn_push;
                sldu_valid_o = active && !up_empty && rx_open;
                up_pop       = sldu_valid_o && sldu_ready_i;
                rx_inc       = up_pop;
            end
            ModeFork: begin
                sldu_valid_o = active && !up_empty && !dn_full && rx_open;
                up_pop       = sldu_valid_o && sldu_ready_i;
                dn_push      = up_pop;
                rx_inc       = up_pop;
            end
            default: begin
                up_pop  = active && !up_empty && !dn_full && rx_open;
                dn_push = up_pop;
                rx_inc  = up_pop;
            end
        endcase

        ring_left_ready_o  = active && dir_q && !in_l_full && up_budget;
        ring_right_ready_o = active && !dir_q && !in_r_full && up_budget;
        ring_left_valid_o  = running && !dir_q && !out_l_empty;
        ring_right_valid_o = running && dir_q && !out_r_empty;
    end

    assign in_l_push  = ring_left_valid_i && ring_left_ready_o;
    assign in_r_push  = ring_right_valid_i && ring_right_ready_o;
    assign in_l_pop   = up_pop && dir_q;
    assign in_r_pop   = up_pop && !dir_q;
    assign out_l_push = dn_push && !dir_q;
    assign out_r_push = dn_push && dir_q;
    assign out_l_pop  = ring_left_valid_o && ring_left_ready_i;
    assign out_r_pop  = ring_right_valid_o && ring_right_ready_i;

    assign sldu_o       = sldu_valid_o ? up_data : '0;
    assign ring_left_o  = ring_left_valid_o ? out_l_data : '0;
    assign ring_right_o = ring_right_valid_o ? out_r_data : '0;

    ring_router_mc_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_in_l (
        .clk_i, .rst_ni, .clr_i(flush_i), .push_i(in_l_push), .data_i(ring_left_i),
        .pop_i(in_l_pop), .data_o(in_l_data), .count_o(in_l_cnt));
    ring_router_mc_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_in_r (
        .clk_i, .rst_ni, .clr_i(flush_i), .push_i(in_r_push), .data_i(ring_right_i),
        .pop_i(in_r_pop), .data_o(in_r_data), .count_o(in_r_cnt));
    ring_router_mc_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_out_l (
        .clk_i, .rst_ni, .clr_i(flush_i), .push_i(out_l_push), .data_i(dn_data),
        .pop_i(out_l_pop), .data_o(out_l_data), .count_o(out_l_cnt));
    ring_router_mc_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_out_r (
        .clk_i, .rst_ni, .clr_i(flush_i), .push_i(out_r_push), .data_i(dn_data),
        .pop_i(out_r_pop), .data_o(out_r_data), .count_o(out_r_cnt));

    always_comb begin
        state_d      = state_q;
        conf_ready_o = (state_q == StIdle);
        busy_o       = (state_q != StIdle);
        done_o       = 1'b0;
        cfg_load     = (state_q == StIdle) && conf_valid_i;
        cnt_done     = (rx_cnt_q == len_q) && ((mode_q != ModeLocal) || (tx_cnt_q == len_q));
        case (state_q)
            StIdle:   if (cfg_load) state_d = StActive;
            StActive: begin
                if (flush_i)       state_d = StIdle;
                else if (cnt_done) state_d = StDrain;
            end
            StDrain: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (dn_empty) begin
                    state_d = StIdle;
                    done_o  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            dir_q    <= 1'b0;
            mode_q   <= ModeLocal;
            len_q    <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                dir_q    <= conf_dir_i;
                mode_q   <= conf_mode_i;
                len_q    <= conf_len_i;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
            end else if (flush_i && (state_q != StIdle)) begin
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (tx_inc) tx_cnt_q <= tx_cnt_q + LenWidth'(1);
                if (rx_inc) rx_cnt_q <= rx_cnt_q + LenWidth'(1);
            end
        end
    end
endmodule

// File: tb/tb_ring_router_mc.sv
// tb/tb_ring_router_mc.sv - directed vectors and sequences for ring_router_mc
module tb_ring_router_mc;
    typedef logic [63:0] dq_t[$];

    typedef struct {
        logic        cv;
        logic [1:0]  mode;
        logic        dir;
        logic [15:0] len;
        logic        s_valid;
        logic [63:0] s_data;
        logic        rr_valid;
        logic [63:0] rr_data;
        logic        e_cr;
        logic        e_busy;
        logic        e_done;
        logic        e_sr;
        logic        e_sv;
        logic [63:0] e_sd;
        logic        e_rlv;
        logic [63:0] e_rld;
        logic        e_rrr;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        conf_valid_i, conf_ready_o, conf_dir_i;
    logic [1:0]  conf_mode_i;
    logic [15:0] conf_len_i;
    logic        flush_i;
    logic [63:0] sldu_i, sldu_o, ring_left_i, ring_right_i, ring_left_o, ring_right_o;
    logic        sldu_valid_i, sldu_ready_o, sldu_valid_o, sldu_ready_i;
    logic        ring_left_valid_i, ring_left_ready_o, ring_right_valid_i, ring_right_ready_o;
    logic        ring_left_valid_o, ring_left_ready_i, ring_right_valid_o, ring_right_ready_i;
    logic        busy_o, done_o;

    always #5 clk_i = ~clk_i;

    ring_router_mc dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .conf_valid_i(conf_valid_i), .conf_ready_o(conf_ready_o), .conf_dir_i(conf_dir_i),
        .conf_mode_i(conf_mode_i), .conf_len_i(conf_len_i), .flush_i(flush_i),
        .sldu_i(sldu_i), .sldu_valid_i(sldu_valid_i), .sldu_ready_o(sldu_ready_o),
        .sldu_o(sldu_o), .sldu_valid_o(sldu_valid_o), .sldu_ready_i(sldu_ready_i),
        .ring_left_i(ring_left_i), .ring_left_valid_i(ring_left_valid_i), .ring_left_ready_o(ring_left_ready_o),
        .ring_right_i(ring_right_i), .ring_right_valid_i(ring_right_valid_i), .ring_right_ready_o(ring_right_ready_o),
        .ring_left_o(ring_left_o), .ring_left_valid_o(ring_left_valid_o), .ring_left_ready_i(ring_left_ready_i),
        .ring_right_o(ring_right_o), .ring_right_valid_o(ring_right_valid_o), .ring_right_ready_i(ring_right_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    int   n_pass = 0, n_total = 0;
    dq_t  q_rl, q_rr, q_sl, src_sl, src_rl, src_rr, exp_q;
    int   rl_in_hs, rr_in_hs, s_in_hs, done_cnt, svo_seen, sro_seen;
    logic tog_srdy = 1'b0;
    vec_t tbl[8];

    always @(negedge clk_i) begin
        if (ring_left_valid_o && ring_left_ready_i)   q_rl.push_back(ring_left_o);
        if (ring_right_valid_o && ring_right_ready_i) q_rr.push_back(ring_right_o);
        if (sldu_valid_o && sldu_ready_i)             q_sl.push_back(sldu_o);
        if (ring_left_valid_i && ring_left_ready_o)   rl_in_hs++;
        if (ring_right_valid_i && ring_right_ready_o) rr_in_hs++;
        if (sldu_valid_i && sldu_ready_o)             s_in_hs++;
        if (done_o)       done_cnt++;
        if (sldu_valid_o) svo_seen++;
        if (sldu_ready_o) sro_seen++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_q(input string name, input dq_t act);
        chk({name, "_count"}, 64'(act.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_%0d", name, i), (i < act.size()) ? act[i] : 64'hx, exp_q[i]);
    endtask

    task automatic clear_mon();
        q_rl.delete(); q_rr.delete(); q_sl.delete();
        rl_in_hs = 0; rr_in_hs = 0; s_in_hs = 0;
        done_cnt = 0; svo_seen = 0; sro_seen = 0;
    endtask

    task automatic drive_src();
        sldu_valid_i       = src_sl.size() > 0;
        sldu_i             = (src_sl.size() > 0) ? src_sl[0] : 64'h0;
        ring_left_valid_i  = src_rl.size() > 0;
        ring_left_i        = (src_rl.size() > 0) ? src_rl[0] : 64'h0;
        ring_right_valid_i = src_rr.size() > 0;
        ring_right_i       = (src_rr.size() > 0) ? src_rr[0] : 64'h0;
    endtask

    // Enter at posedge+1 with inputs applied; leave at the next posedge+1.
    task automatic cycle();
        logic hs_s, hs_l, hs_r;
        logic [63:0] tmp;
        @(negedge clk_i);
        hs_s = sldu_valid_i && sldu_ready_o;
        hs_l = ring_left_valid_i && ring_left_ready_o;
        hs_r = ring_right_valid_i && ring_right_ready_o;
        @(posedge clk_i);
        #1;
        if (hs_s) tmp = src_sl.pop_front();
        if (hs_l) tmp = src_rl.pop_front();
        if (hs_r) tmp = src_rr.pop_front();
        if (tog_srdy) sldu_ready_i = ~sldu_ready_i;
        drive_src();
    endtask

    task automatic start(input logic [1:0] m, input logic d, input logic [15:0] l);
        conf_mode_i  = m;
        conf_dir_i   = d;
        conf_len_i   = l;
        conf_valid_i = 1'b1;
        drive_src();
        cycle();
        conf_valid_i = 1'b0;
    endtask

    task automatic run_done(input int budget, input string name);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic chk_reset_outs(input string p);
        chk({p, "_conf_ready"}, conf_ready_o, 1);
        chk({p, "_busy"}, busy_o, 0);
        chk({p, "_done"}, done_o, 0);
        chk({p, "_sldu_ready"}, sldu_ready_o, 0);
        chk({p, "_sldu_valid"}, sldu_valid_o, 0);
        chk({p, "_rl_ready"}, ring_left_ready_o, 0);
        chk({p, "_rr_ready"}, ring_right_ready_o, 0);
        chk({p, "_rl_valid"}, ring_left_valid_o, 0);
        chk({p, "_rr_valid"}, ring_right_valid_o, 0);
        chk({p, "_sldu_data"}, sldu_o, 0);
        chk({p, "_rl_data"}, ring_left_o, 0);
        chk({p, "_rr_data"}, ring_right_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; conf_valid_i = 1'b0;
        conf_dir_i = 1'b0; conf_mode_i = 2'd0; conf_len_i = 16'd0;
        sldu_ready_i = 1'b1; ring_left_ready_i = 1'b1; ring_right_ready_i = 1'b0;
        clear_mon();
        drive_src();
        repeat (3) @(posedge clk_i);
        #2;
        chk_reset_outs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // LOCAL dir 0 len 3: A,B,C out on ring_left_o, X,Y,Z out on sldu_o
        tbl[0] = '{1, 2'd0, 0, 16'd3, 0, 64'h0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,  0, 64'h0,  0};
        tbl[1] = '{0, 2'd0, 0, 16'd0, 1, 64'hA, 1, 64'h11,  0, 1, 0, 1, 0, 64'h0,  0, 64'h0,  1};
        tbl[2] = '{0, 2'd0, 0, 16'd0, 1, 64'hB, 1, 64'h22,  0, 1, 0, 1, 1, 64'h11, 1, 64'hA,  1};
        tbl[3] = '{0, 2'd0, 0, 16'd0, 1, 64'hC, 1, 64'h33,  0, 1, 0, 1, 1, 64'h22, 1, 64'hB,  1};
        tbl[4] = '{0, 2'd0, 0, 16'd0, 0, 64'h0, 0, 64'h0,   0, 1, 0, 0, 1, 64'h33, 1, 64'hC,  0};
        tbl[5] = '{0, 2'd0, 0, 16'd0, 0, 64'h0, 0, 64'h0,   0, 1, 0, 0, 0, 64'h0,  0, 64'h0,  0};
        tbl[6] = '{0, 2'd0, 0, 16'd0, 0, 64'h0, 0, 64'h0,   0, 1, 1, 0, 0, 64'h0,  0, 64'h0,  0};
        tbl[7] = '{0, 2'd0, 0, 16'd0, 0, 64'h0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0,  0, 64'h0,  0};
        for (int i = 0; i < 8; i++) begin
            conf_valid_i = tbl[i].cv; conf_mode_i = tbl[i].mode;
            conf_dir_i = tbl[i].dir; conf_len_i = tbl[i].len;
            sldu_valid_i = tbl[i].s_valid; sldu_i = tbl[i].s_data;
            ring_right_valid_i = tbl[i].rr_valid; ring_right_i = tbl[i].rr_data;
            ring_left_valid_i = 1'b0; ring_left_i = 64'h0;
            @(negedge clk_i);
            chk($sformatf("local%0d_conf_ready", i), conf_ready_o, tbl[i].e_cr);
            chk($sformatf("local%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("local%0d_done", i), done_o, tbl[i].e_done);
            chk($sformatf("local%0d_sldu_ready", i), sldu_ready_o, tbl[i].e_sr);
            chk($sformatf("local%0d_sldu_valid", i), sldu_valid_o, tbl[i].e_sv);
            if (tbl[i].e_sv) chk($sformatf("local%0d_sldu_data", i), sldu_o, tbl[i].e_sd);
            chk($sformatf("local%0d_rl_valid", i), ring_left_valid_o, tbl[i].e_rlv);
            if (tbl[i].e_rlv) chk($sformatf("local%0d_rl_data", i), ring_left_o, tbl[i].e_rld);
            chk($sformatf("local%0d_rr_ready", i), ring_right_ready_o, tbl[i].e_rrr);
            chk($sformatf("local%0d_rr_valid", i), ring_right_valid_o, 0);
            @(posedge clk_i);
            #1;
        end
        conf_valid_i = 1'b0;

        // BYPASS dir 1 len 4 with a stalled right sink
        clear_mon();
        for (int i = 0; i < 4; i++) src_rl.push_back(64'hD0 + 64'(i));
        ring_right_ready_i = 1'b0; ring_left_ready_i = 1'b0; sldu_ready_i = 1'b1;
        start(2'd1, 1'b1, 16'd4);
        repeat (5) cycle();
        chk("byp_accepted_while_stalled", 64'(rl_in_hs), 64'd4);
        chk("byp_rl_ready_dropped", ring_left_ready_o, 0);
        chk("byp_rr_valid_held", ring_right_valid_o, 1);
        ring_right_ready_i = 1'b1;
        run_done(40, "byp");
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(64'hD0 + 64'(i));
        chk_q("byp_rr_out", q_rr);
        chk("byp_sldu_valid_never", 64'(svo_seen), 64'd0);
        chk("byp_conf_ready_after", conf_ready_o, 1);

        // FORK dir 0 len 2 with toggling sldu_ready_i
        clear_mon();
        src_rr.push_back(64'hF1); src_rr.push_back(64'hF2);
        ring_left_ready_i = 1'b1; sldu_ready_i = 1'b0; tog_srdy = 1'b1;
        start(2'd2, 1'b0, 16'd2);
        run_done(40, "fork");
        tog_srdy = 1'b0; sldu_ready_i = 1'b1;
        exp_q.delete(); exp_q.push_back(64'hF1); exp_q.push_back(64'hF2);
        chk_q("fork_sldu_out", q_sl);
        chk_q("fork_rl_out", q_rl);
        chk("fork_rx_cnt", 64'(dut.rx_cnt_q), 64'd2);
        chk("fork_done_once", 64'(done_cnt), 64'd1);
        chk("fork_sldu_ready_never", 64'(sro_seen), 64'd0);

        // len 0 in every mode: prompt done, no handshakes
        ring_right_ready_i = 1'b1;
        for (int m = 0; m < 4; m++) begin
            int n;
            clear_mon();
            src_sl.push_back(64'hE0); src_rl.push_back(64'hE1); src_rr.push_back(64'hE2);
            start(2'(m), m[0], 16'd0);
            n = 1;
            while (done_cnt == 0 && n < 6) begin
                cycle();
                n++;
            end
            chk($sformatf("len0_m%0d_done_in_3", m), 64'(done_cnt == 1 && n <= 3), 64'd1);
            chk($sformatf("len0_m%0d_handshakes", m),
                64'(rl_in_hs + rr_in_hs + s_in_hs + q_rl.size() + q_rr.size() + q_sl.size()), 64'd0);
            src_sl.delete(); src_rl.delete(); src_rr.delete();
            drive_src();
        end

        // flush after the first of four bypass beats
        begin
            int n;
            clear_mon();
            for (int i = 0; i < 4; i++) src_rr.push_back(64'hB0 + 64'(i));
            start(2'd1, 1'b0, 16'd4);
            n = 0;
            while (q_rl.size() < 1 && n < 20) begin
                cycle();
                n++;
            end
            chk("flush_first_beat_out", 64'(q_rl.size()), 64'd1);
            src_rr.delete();
            drive_src();
            flush_i = 1'b1;
            cycle();
            flush_i = 1'b0;
            chk("flush_busy", busy_o, 0);
            chk("flush_rl_valid", ring_left_valid_o, 0);
            chk("flush_rr_valid", ring_right_valid_o, 0);
            chk("flush_sldu_valid", sldu_valid_o, 0);
            chk("flush_no_done", 64'(done_cnt), 64'd0);
            chk("flush_conf_ready", conf_ready_o, 1);
            clear_mon();
            src_rr.push_back(64'hCAFE);
            start(2'd1, 1'b0, 16'd1);
            run_done(20, "postflush");
            exp_q.delete(); exp_q.push_back(64'hCAFE);
            chk_q("postflush_rl_out", q_rl);
        end

        // reset in the middle of a LOCAL dir 1 transfer
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            src_sl.push_back(64'h50 + 64'(i));
            src_rl.push_back(64'h60 + 64'(i));
        end
        ring_right_ready_i = 1'b0; sldu_ready_i = 1'b0;
        start(2'd0, 1'b1, 16'd3);
        repeat (3) cycle();
        chk("midrst_busy_before", busy_o, 1);
        src_sl.delete(); src_rl.delete();
        drive_src();
        rst_ni = 1'b0;
        #2;
        chk_reset_outs("midrst");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ring_right_ready_i = 1'b1; sldu_ready_i = 1'b1;
        cycle();
        chk("postrst_busy", busy_o, 0);
        chk("postrst_rr_valid", ring_right_valid_o, 0);
        chk("postrst_sldu_valid", sldu_valid_o, 0);
        clear_mon();
        src_sl.push_back(64'h71); src_sl.push_back(64'h72);
        src_rl.push_back(64'h81); src_rl.push_back(64'h82);
        start(2'd0, 1'b1, 16'd2);
        run_done(40, "postrst");
        exp_q.delete(); exp_q.push_back(64'h71); exp_q.push_back(64'h72);
        chk_q("postrst_rr_out", q_rr);
        exp_q.delete(); exp_q.push_back(64'h81); exp_q.push_back(64'h82);
        chk_q("postrst_sldu_out", q_sl);
        chk("postrst_done_once", 64'(done_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
